// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection pipeline: default image geometry
// and the window-generator state encoding, used by the control unit,
// the window generator and the convolution stage.
package edge_pkg;

  localparam int CWG_DATA_W = 8;
  localparam int CWG_IMG_W  = 64;
  localparam int CWG_IMG_H  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } cwg_state_t;

endpackage

// File: rtl/line_buffer.sv
// Single-row delay line, IMG_W entries of DATA_W bits.
// Read is combinational on idx_i and returns the old entry; a write on the
// same edge replaces it, so chaining two instances gives two row delays.
module line_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IDX_W  = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  // Row storage; contents need no reset because every entry is written
  // before it is read into an emitted window.
  logic [DATA_W-1:0] mem_q [IMG_W];

  // Write the incoming pixel into its column slot.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= din_i;
    end
  end

  assign dout_o = mem_q[idx_i];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, one window per interior
// pixel out, one cycle after the accept that completes it.
// Optional centre-coordinate outputs win_x/win_y when CONV_WINDOW_COORD_EN is defined.
module conv_window_gen
  import edge_pkg::*;
#(
  parameter int DATA_W = CWG_DATA_W,
  parameter int IMG_W  = CWG_IMG_W,
  parameter int IMG_H  = CWG_IMG_H
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pix_valid,
  input  logic [DATA_W-1:0]   pix_data,
  output logic                pix_ready,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [9*DATA_W-1:0] window,
  output logic                busy,
  output logic                frame_done
`ifdef CONV_WINDOW_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  cwg_state_t          state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic                win_valid_q, win_valid_d;
  logic [9*DATA_W-1:0] win_q, win_d;
  logic [DATA_W-1:0]   lb0_dout, lb1_dout;
  logic                accept;
  logic                qualify;
  logic                last_pix;

  // An accept is blocked whenever a window is waiting, so the shift register
  // (which is also the output) cannot move under a stall.
  assign pix_ready = (state_q == STREAM) && (!win_valid_q || win_ready);
  assign accept    = pix_valid && pix_ready;
  assign qualify   = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);

  line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IDX_W(CW)) u_lb0 (
    .clk    (clk),
    .we_i   (accept),
    .idx_i  (col_q),
    .din_i  (pix_data),
    .dout_o (lb0_dout)
  );

  line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IDX_W(CW)) u_lb1 (
    .clk    (clk),
    .we_i   (accept),
    .idx_i  (col_q),
    .din_i  (lb0_dout),
    .dout_o (lb1_dout)
  );

  // Frame sequencing: arm on start, drain the final window, pulse done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (accept && last_pix) state_d = DRAIN;
      DRAIN:   if (!win_valid_q || win_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if ((state_q == IDLE) && start) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Window shift: columns move left, new right column is {row-2, row-1, row}.
  always_comb begin
    win_d       = win_q;
    win_valid_d = win_valid_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[DATA_W*(3*r+0) +: DATA_W] = win_q[DATA_W*(3*r+1) +: DATA_W];
        win_d[DATA_W*(3*r+1) +: DATA_W] = win_q[DATA_W*(3*r+2) +: DATA_W];
      end
      win_d[DATA_W*2 +: DATA_W] = lb1_dout;
      win_d[DATA_W*5 +: DATA_W] = lb0_dout;
      win_d[DATA_W*8 +: DATA_W] = pix_data;
    end
    if (accept && qualify) begin
      win_valid_d = 1'b1;
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  // State, counters and window registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
    end
  end

`ifdef CONV_WINDOW_COORD_EN
  logic [CW-1:0] win_x_q;
  logic [RW-1:0] win_y_q;

  // Centre coordinate captured alongside the window it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_x_q <= '0;
      win_y_q <= '0;
    end else if (accept && qualify) begin
      win_x_q <= col_q - CW'(1);
      win_y_q <= row_q - RW'(1);
    end
  end

  assign win_x = win_x_q;
  assign win_y = win_y_q;
`endif

  assign window     = win_q;
  assign win_valid  = win_valid_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: an 8x8 instance driven through a table
// of frame scenarios plus hand sequences, and a 3x3 instance for minimum size.
module tb_conv_window_gen;

  logic        clk;
  logic        reset;
  logic        start, pix_valid, pix_ready, win_valid, win_ready, busy, frame_done;
  logic [7:0]  pix_data;
  logic [71:0] window;
  logic        s_start, s_pix_valid, s_pix_ready, s_win_valid, s_win_ready, s_busy, s_frame_done;
  logic [7:0]  s_pix_data;
  logic [71:0] s_window;
`ifdef CONV_WINDOW_COORD_EN
  logic [2:0]  win_x, win_y;
  logic [1:0]  s_win_x, s_win_y;
`endif

  int n_cmp = 0;
  int n_err = 0;

  conv_window_gen #(.DATA_W(8), .IMG_W(8), .IMG_H(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .win_valid(win_valid),
    .win_ready(win_ready), .window(window), .busy(busy), .frame_done(frame_done)
`ifdef CONV_WINDOW_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );

  conv_window_gen #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .pix_valid(s_pix_valid),
    .pix_data(s_pix_data), .pix_ready(s_pix_ready), .win_valid(s_win_valid),
    .win_ready(s_win_ready), .window(s_window), .busy(s_busy), .frame_done(s_frame_done)
`ifdef CONV_WINDOW_COORD_EN
    , .win_x(s_win_x), .win_y(s_win_y)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    bubble;
    int    stall_at;
    int    stall_len;
    int    exp_cnt;
    int    start_at;
  } cfg_t;

  cfg_t tbl[4];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pk(input int e0, input int e1, input int e2,
                                     input int e3, input int e4, input int e5,
                                     input int e6, input int e7, input int e8);
    logic [71:0] w;
    w = {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    return w;
  endfunction

  // Expected window completed by accepting pixel (row, col) of the 8x8 ramp image.
  function automatic logic [71:0] ewin(input int row, input int col);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[8*(3*r+c) +: 8] = 8'((row - 2 + r) * 8 + (col - 2 + c));
    return w;
  endfunction

  // Runs one 8x8 frame; called and returns 1 time unit after a rising edge.
  task automatic run_frame(input cfg_t c);
    int          p = 0, got = 0, cyc = 0, done_cnt = 0, post = 0, stall_left;
    logic        exp_next = 1'b0, stalled_prev = 1'b0, acc, phase = 1'b1, pulsed = 1'b0;
    logic [71:0] exp_w = '0, held_w = '0, first_w = '0, last_w = '0;
    int          cy, cx;
    stall_left = c.stall_len;
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'd0;
    win_ready = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      if (exp_next) begin
        chk({c.name, "_lat_vld"}, win_valid, 1'b1);
        chk({c.name, "_lat_win"}, window, exp_w);
      end
      if (stalled_prev) chk({c.name, "_stall_hold"}, window, held_w);
      if (win_valid && !win_ready) chk({c.name, "_stall_pix_ready"}, pix_ready, 1'b0);
      if (win_valid && win_ready) begin
        if (got < c.exp_cnt) begin
          cy = 1 + got / 6;
          cx = 1 + got % 6;
          chk({c.name, "_win_seq"}, window, ewin(cy + 1, cx + 1));
        end
        if (got == 0) first_w = window;
        last_w = window;
        got++;
      end
      if (frame_done) done_cnt++;
      if (done_cnt > 0) post++;
      if (post > 3) break;
      acc = pix_valid && pix_ready;
      exp_next = 1'b0;
      if (acc) begin
        if ((p / 8) >= 2 && (p % 8) >= 2) begin
          exp_next = 1'b1;
          exp_w    = ewin(p / 8, p % 8);
        end
        p++;
      end
      stalled_prev = win_valid && !win_ready;
      held_w       = window;
      @(posedge clk); #1;
      cyc++;
      phase     = c.bubble != 0 ? ~phase : 1'b1;
      pix_valid = (p < 64) && phase;
      pix_data  = 8'(p);
      start     = 1'b0;
      if (!pulsed && p == c.start_at) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (got == c.stall_at && stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
      end else begin
        win_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    start     = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b1;
    chk({c.name, "_timeout"}, cyc < 3000, 1'b1);
    chk({c.name, "_win_count"}, got, c.exp_cnt);
    chk({c.name, "_done_pulses"}, done_cnt, 1);
    chk({c.name, "_first_win"}, first_w, pk(0, 1, 2, 8, 9, 10, 16, 17, 18));
    chk({c.name, "_last_win"}, last_w, pk(45, 46, 47, 53, 54, 55, 61, 62, 63));
    chk({c.name, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    int          sp, sn, sd;
    logic        sacc;
    logic [71:0] sw;

    tbl[0] = '{"basic",     0, -1, 0, 36, -1};
    tbl[1] = '{"stall",     0, 10, 5, 36, -1};
    tbl[2] = '{"bubble",    1, -1, 0, 36, -1};
    tbl[3] = '{"startbusy", 0, -1, 0, 36, 30};

    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b1;
    s_start = 1'b0; s_pix_valid = 1'b0; s_pix_data = '0; s_win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_win_valid", win_valid, 1'b0);
    chk("rst_window", window, 72'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_small_busy", s_busy, 1'b0);
    reset = 1'b0;

    // Offered pixels before any start must be refused.
    pix_valid = 1'b1;
    pix_data  = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      chk("prestart_pix_ready", pix_ready, 1'b0);
      chk("prestart_busy", busy, 1'b0);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;

    for (int i = 0; i < 4; i++) run_frame(tbl[i]);

    // Abort a frame with reset after 20 pixels, then run a clean frame.
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    pix_valid = 1'b1;
    win_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pix_data = 8'(k);
      @(posedge clk); #1;
    end
    chk("mid_busy", busy, 1'b1);
    chk("mid_win_valid", win_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_pix_ready", pix_ready, 1'b0);
    chk("abort_win_valid", win_valid, 1'b0);
    chk("abort_window", window, 72'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_frame_done", frame_done, 1'b0);
    pix_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", frame_done, 1'b0);
    end
    @(posedge clk); #1;
    run_frame(tbl[0]);

    // Minimum 3x3 image: one window then done.
    sp = 0; sn = 0; sd = 0; sw = '0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start     = 1'b0;
    s_pix_valid = 1'b1;
    s_pix_data  = 8'd1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (s_win_valid && s_win_ready) begin
        sn++;
        sw = s_window;
      end
      if (s_frame_done) sd++;
      sacc = s_pix_valid && s_pix_ready;
      @(posedge clk); #1;
      if (sacc) sp++;
      s_pix_valid = sp < 9;
      s_pix_data  = 8'(sp + 1);
    end
    chk("small_win_count", sn, 1);
    chk("small_window", sw, pk(1, 2, 3, 4, 5, 6, 7, 8, 9));
    chk("small_done_pulses", sd, 1);
    chk("small_busy", s_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
